// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: two-requester round-robin front end for an MSB-first
// parallel-in/serial-out shifter with frame markers (first/last bit) and a
// programmable idle gap after each frame.
//
// Handshake: REQn_READY is combinational and high only in IDLE for at most
// one requester; a word transfers on the rising edge where REQn_VALID and
// REQn_READY are both high. VALID may drop before it is granted, and no
// state is kept for a dropped request.
//
// Build option: define PISO_TX_PARITY_EN to append an even-parity bit
// (XOR of the data bits, taken at accept time) as the final frame bit.
// Without it, the frame is exactly WIDTH bits and SER_LAST marks the LSB.
//
// o_dbg_state exposes the FSM state (0 IDLE, 1 SHIFT, 2 GAP).
module piso_tx_arbiter #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             REQ0_VALID,
   input  logic [WIDTH-1:0] REQ0_DATA,
   output logic             REQ0_READY,
   input  logic             REQ1_VALID,
   input  logic [WIDTH-1:0] REQ1_DATA,
   output logic             REQ1_READY,
   output logic             SER_OUT,
   output logic             SER_VALID,
   output logic             SER_FIRST,
   output logic             SER_LAST,
   output logic             GRANT_ID,
   output logic             BUSY,
   output logic [1:0]       o_dbg_state
);

`ifdef PISO_TX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int            CW       = $clog2(FRAME);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
   localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       r_state;
   logic [FRAME-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_gap_cnt;
   logic             r_ptr;
   logic             r_grant;

   logic             w_idle;
   logic             w_shift;
   logic             w_rdy0;
   logic             w_rdy1;
   logic             w_accept;
   logic [WIDTH-1:0] w_win_data;
   logic [FRAME-1:0] w_load;
   logic             w_last;

   assign w_idle  = (r_state == S_IDLE);
   assign w_shift = (r_state == S_SHIFT);

   // A lone requester always wins; when both ask, the pointer decides.
   assign w_rdy0   = w_idle & REQ0_VALID & (~REQ1_VALID | ~r_ptr);
   assign w_rdy1   = w_idle & REQ1_VALID & (~REQ0_VALID |  r_ptr);
   assign w_accept = w_rdy0 | w_rdy1;

   assign w_win_data = w_rdy1 ? REQ1_DATA : REQ0_DATA;

`ifdef PISO_TX_PARITY_EN
   // Parity sits below the data LSB so plain left shifting sends it last.
   assign w_load = {w_win_data, ^w_win_data};
`else
   assign w_load = w_win_data;
`endif

   assign w_last = (r_cnt == CNT_LAST);

   // FSM, shifter, counters, grant and round-robin pointer.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_gap_cnt <= '0;
         r_ptr     <= 1'b0;
         r_grant   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift <= w_load;
                  r_grant <= w_rdy1;
                  // Pointer flips on every grant, contested or not.
                  r_ptr   <= ~r_ptr;
                  r_cnt   <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_shift <= {r_shift[FRAME-2:0], 1'b0};
               if (w_last) begin
                  r_cnt     <= '0;
                  r_gap_cnt <= '0;
                  r_state   <= (GAP > 0) ? S_GAP : S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign REQ0_READY  = w_rdy0;
   assign REQ1_READY  = w_rdy1;
   assign SER_VALID   = w_shift;
   assign SER_OUT     = w_shift & r_shift[FRAME-1];
   assign SER_FIRST   = w_shift & (r_cnt == '0);
   assign SER_LAST    = w_shift & w_last;
   assign GRANT_ID    = r_grant;
   assign BUSY        = ~w_idle;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter: a GAP=1 instance covers reset, single
// and contested requests, back-to-back words, pointer behaviour and async
// reset mid-frame; a GAP=0 instance covers the minimum inter-frame spacing.
// With PISO_TX_PARITY_EN defined the expected frames include the parity bit.
module tb_piso_tx_arbiter;

`ifdef PISO_TX_PARITY_EN
   localparam int FRAME = 5;
`else
   localparam int FRAME = 4;
`endif
   localparam int PERIOD = FRAME + 1 + 1;   // FRAME + GAP + 1 with GAP = 1

   // ---------------- clock / reset ----------------
   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   int         cyc = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- GAP=1 DUT ----------------
   logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
   logic [3:0] REQ0_DATA = '0, REQ1_DATA = '0;
   logic       REQ0_READY, REQ1_READY;
   logic       SER_OUT, SER_VALID, SER_FIRST, SER_LAST, GRANT_ID, BUSY;
   logic [1:0] dbg_state;

   piso_tx_arbiter #(.WIDTH(4), .GAP(1)) u_dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
      .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
      .SER_OUT(SER_OUT), .SER_VALID(SER_VALID), .SER_FIRST(SER_FIRST),
      .SER_LAST(SER_LAST), .GRANT_ID(GRANT_ID), .BUSY(BUSY),
      .o_dbg_state(dbg_state)
   );

   // ---------------- GAP=0 DUT ----------------
   logic       g0_v0 = 1'b0, g0_v1 = 1'b0;
   logic [3:0] g0_d0 = '0, g0_d1 = '0;
   logic       g0_rdy0, g0_rdy1;
   logic       g0_out, g0_valid, g0_first, g0_last, g0_grant, g0_busy;
   logic [1:0] g0_state;

   piso_tx_arbiter #(.WIDTH(4), .GAP(0)) u_dut_g0 (
      .CLK(CLK), .RST_N(RST_N),
      .REQ0_VALID(g0_v0), .REQ0_DATA(g0_d0), .REQ0_READY(g0_rdy0),
      .REQ1_VALID(g0_v1), .REQ1_DATA(g0_d1), .REQ1_READY(g0_rdy1),
      .SER_OUT(g0_out), .SER_VALID(g0_valid), .SER_FIRST(g0_first),
      .SER_LAST(g0_last), .GRANT_ID(g0_grant), .BUSY(g0_busy),
      .o_dbg_state(g0_state)
   );

   // ---------------- scoreboard ----------------
   logic [2:0] exp_q[$];     // {first, last, bit}
   logic [2:0] mon_e;
   int         n_checks = 0;
   int         n_errs = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [FRAME-1:0] frame_bits(input logic [3:0] d);
`ifdef PISO_TX_PARITY_EN
      return {d, ^d};
`else
      return d;
`endif
   endfunction

   task automatic push_word(input logic [3:0] d);
      logic [FRAME-1:0] b;
      b = frame_bits(d);
      for (int i = FRAME - 1; i >= 0; i--)
         exp_q.push_back({(i == FRAME - 1), (i == 0), b[i]});
   endtask

   // Serial monitor for the GAP=1 instance.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (SER_VALID) begin
            if (exp_q.size() == 0) begin
               check("ser_unexpected", 32'(SER_VALID), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("ser_bit", 32'({SER_FIRST, SER_LAST, SER_OUT}), 32'(mon_e));
            end
         end else begin
            check("ser_idle_zero", 32'({SER_FIRST, SER_LAST, SER_OUT}), 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RST_N = 1'b0;
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      @(negedge CLK);
      check("rst_ser", 32'({SER_VALID, SER_OUT, SER_FIRST, SER_LAST}), 32'd0);
      check("rst_busy_grant", 32'({BUSY, GRANT_ID}), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_ready", 32'({REQ0_READY, REQ1_READY}), 32'd0);
      nxt();
      RST_N = 1'b1;
   endtask

   // Wait (bounded) for the GAP=1 DUT to leave SHIFT/GAP, then step to post-edge.
   task automatic drain(input string tag);
      for (int k = 0; k < 30 && BUSY; k++) @(negedge CLK);
      check({tag, "_drain_busy"}, 32'(BUSY), 32'd0);
      check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
      nxt();
   endtask

   // Bounded wait for REQ1_READY at a negedge; returns 1 when seen.
   task automatic wait_rdy1(output logic found);
      found = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge CLK);
         if (REQ1_READY) begin
            found = 1'b1;
            break;
         end
         nxt();
      end
   endtask

   // ---------------- directed sequence ----------------
   logic [3:0]       words [3];
   logic             found;
   int               last_acc;
   int               n_wait;
   logic [FRAME-1:0] b;

   initial begin
      words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;

      // Reset state
      apply_reset();

      // 1: single word 4'b1011 from requester 0
      REQ0_VALID = 1'b1; REQ0_DATA = 4'b1011;
      push_word(4'b1011);
      @(negedge CLK);
      check("t1_rdy", 32'({REQ0_READY, REQ1_READY}), 32'b10);
      check("t1_busy_idle", 32'(BUSY), 32'd0);
      nxt();
      REQ0_VALID = 1'b0;
      @(negedge CLK);
      check("t1_grant", 32'(GRANT_ID), 32'd0);
      check("t1_busy_shift", 32'(BUSY), 32'd1);
      check("t1_rdy_shift", 32'({REQ0_READY, REQ1_READY}), 32'd0);
      repeat (FRAME - 1) nxt();
      nxt();
      @(negedge CLK);
      check("t1_gap", 32'({BUSY, SER_VALID}), 32'b10);
      check("t1_gap_state", 32'(dbg_state), 32'd2);
      nxt();
      @(negedge CLK);
      check("t1_idle_busy", 32'(BUSY), 32'd0);
      check("t1_q_empty", 32'(exp_q.size()), 32'd0);
      nxt();

      // 2: contested first request after reset
      apply_reset();
      REQ0_VALID = 1'b1; REQ0_DATA = 4'hA;
      REQ1_VALID = 1'b1; REQ1_DATA = 4'h5;
      push_word(4'hA);
      @(negedge CLK);
      check("t2_rdy_first", 32'({REQ0_READY, REQ1_READY}), 32'b10);
      nxt();
      REQ0_VALID = 1'b0;
      @(negedge CLK);
      check("t2_grant0", 32'(GRANT_ID), 32'd0);
      nxt();
      n_wait = 0;
      found = 1'b0;
      for (int n = 2; n <= 20; n++) begin
         @(negedge CLK);
         if (REQ1_READY) begin
            found = 1'b1;
            n_wait = n;
            break;
         end
         nxt();
      end
      check("t2_rdy1_seen", 32'(found), 32'd1);
      check("t2_accept_spacing", 32'(n_wait), 32'(PERIOD));
      check("t2_rdy0_low", 32'(REQ0_READY), 32'd0);
      push_word(4'h5);
      nxt();
      REQ1_VALID = 1'b0;
      @(negedge CLK);
      check("t2_grant1", 32'(GRANT_ID), 32'd1);
      drain("t2");

      // 3: requester 1 streams three words, requester 0 idle
      REQ1_VALID = 1'b1; REQ1_DATA = words[0];
      last_acc = 0;
      for (int w = 0; w < 3; w++) begin
         wait_rdy1(found);
         check("t3_rdy1_seen", 32'(found), 32'd1);
         if (w > 0) check("t3_accept_spacing", 32'(cyc - last_acc), 32'(PERIOD));
         last_acc = cyc;
         push_word(words[w]);
         nxt();
         if (w < 2) REQ1_DATA = words[w + 1];
         else REQ1_VALID = 1'b0;
         @(negedge CLK);
         check("t3_grant1", 32'(GRANT_ID), 32'd1);
      end
      drain("t3");

      // 3b: pointer toggled on the uncontested grants, so requester 1 wins;
      // both requests are withdrawn before the edge and leave no trace.
      REQ0_VALID = 1'b1; REQ0_DATA = 4'hC;
      REQ1_VALID = 1'b1; REQ1_DATA = 4'h7;
      @(negedge CLK);
      check("t3b_rdy_ptr", 32'({REQ0_READY, REQ1_READY}), 32'b01);
      #1;
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      nxt();
      @(negedge CLK);
      check("t3b_withdrawn", 32'({BUSY, REQ0_READY, REQ1_READY}), 32'd0);
      nxt();

      // 4: async reset during bit 2 of 4'hF
      REQ0_VALID = 1'b1; REQ0_DATA = 4'hF;
      push_word(4'hF);
      nxt();
      REQ0_VALID = 1'b0;
      @(negedge CLK);
      nxt();
      @(negedge CLK);
      check("t4_bit2_valid", 32'(SER_VALID), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("t4_async_ser", 32'({SER_VALID, SER_OUT, SER_FIRST, SER_LAST}), 32'd0);
      check("t4_async_busy", 32'(BUSY), 32'd0);
      exp_q.delete();
      nxt();
      RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("t4_no_replay", 32'({BUSY, SER_VALID, REQ0_READY, REQ1_READY}), 32'd0);
         nxt();
      end

      // 6: GAP=0 instance, requester 0 holds valid for 4'h9 then 4'h6
      g0_v0 = 1'b1; g0_d0 = 4'h9;
      @(negedge CLK);
      check("t6_rdy_first", 32'(g0_rdy0), 32'd1);
      nxt();
      g0_d0 = 4'h6;
      b = frame_bits(4'h9);
      for (int i = FRAME - 1; i >= 0; i--) begin
         @(negedge CLK);
         check("t6_w0_bit", 32'({g0_valid, g0_first, g0_last, g0_out}),
               32'({1'b1, (i == FRAME - 1), (i == 0), b[i]}));
         nxt();
      end
      @(negedge CLK);
      check("t6_idle_gap", 32'({g0_valid, g0_busy}), 32'd0);
      check("t6_rdy_second", 32'(g0_rdy0), 32'd1);
      nxt();
      g0_v0 = 1'b0;
      b = frame_bits(4'h6);
      for (int i = FRAME - 1; i >= 0; i--) begin
         @(negedge CLK);
         check("t6_w1_bit", 32'({g0_valid, g0_first, g0_last, g0_out}),
               32'({1'b1, (i == FRAME - 1), (i == 0), b[i]}));
         nxt();
      end
      @(negedge CLK);
      check("t6_end_idle", 32'({g0_valid, g0_busy, g0_rdy0}), 32'd0);
      check("t6_grant", 32'(g0_grant), 32'd0);

      check("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

   // Watchdog: the sequence is a few hundred cycles; anything longer is a hang.
   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected sequence completion");
      $fatal(1);
   end

endmodule
